mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store unit sitting directly upstream of the word-wide data memory in the RISC-V datapath. Takes the ALU-computed byte address, store data and funct3 from the execute stage, converts them into word-indexed memory accesses, and returns sign/zero-extended load data. Sub-word stores (SB/SH) use a read-modify-write sequence because the memory only writes whole words. Misaligned accesses are rejected without touching memory.

## Interface
- ADDRESS_WIDTH, 16, word-index width of the data memory (memory holds 2**ADDRESS_WIDTH words)
- DATA_WIDTH, 32, memory word width; only 32 is supported
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  request present; sampled only in IDLE
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  input  32  byte address from ALU
- req_wdata  input  32  store data (rs2)
- busy  output  1  high whenever state != IDLE; core stalls PC on busy
- resp_valid  output  1  one-cycle pulse: access complete
- resp_err  output  1  valid with resp_valid; misaligned or illegal funct3
- load_data  output  32  extended load result, valid with resp_valid on loads
- mem_addr  output  ADDRESS_WIDTH  word index = req_addr[ADDRESS_WIDTH+1:2]
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_WIDTH  word to write
- mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after mem_addr is presented (synchronous read)

## Operation
- Request latched (addr, funct3, store, wdata) on the accept cycle: req_valid high in IDLE.
- Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00. Store with funct3 BU/HU, or funct3 011/110/111, is illegal.
- States: IDLE, LD_WAIT, RMW_WAIT, RMW_WR, ERR.
- IDLE + misaligned/illegal -> ERR; no mem_we.
- IDLE + load -> drive mem_addr, mem_we=0 -> LD_WAIT.
- IDLE + SW -> mem_we=1, mem_wdata=req_wdata, mem_addr driven in accept cycle -> RMW_WR skipped; next state ERR-free completion (resp next cycle via LD_WAIT-equivalent "DONE" pulse handled by IDLE return with registered resp_valid).
- IDLE + SB/SH -> read word -> RMW_WAIT.
- LD_WAIT: select lane from mem_rdata by addr[1:0], extend (B/H sign, BU/HU zero), register into load_data -> IDLE with resp_valid.
- RMW_WAIT: merge store lane(s) into mem_rdata, register merged word -> RMW_WR.
- RMW_WR: mem_we=1, mem_wdata=merged word, same mem_addr -> IDLE with resp_valid.
- ERR: -> IDLE with resp_valid=1, resp_err=1, load_data=0.
- Lane rules: byte k = bits [8k+7:8k] for addr[1:0]=k; halfword at addr[1]=1 uses bits [31:16].

## Timing
- Reset values: busy=0, resp_valid=0, resp_err=0, load_data=0, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE.
- mem_we is forced 0 in any cycle rst is high; reset mid-operation abandons the access with no write and no resp_valid.
- Accept at cycle T. Load: resp_valid at T+2. SW: write at T, resp_valid at T+1. SB/SH: read at T, write at T+2, resp_valid at T+3. Error: resp_valid at T+1.
- resp_valid is registered, exactly one cycle, coincident with state returning to IDLE; a new request may be accepted in that same cycle.
- req_valid while busy is ignored; requester must re-present after resp_valid.
- busy is registered from state; the accept cycle itself reports busy=0 (core must treat req_valid & IDLE as a stall cause).

## Structure
- Package lsu_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU) and state enum lsu_state_t.
- Sub-module lsu_lane: combinational lane extract/extend and lane merge, given addr[1:0], funct3, word and store data. FSM, latches and memory-side outputs stay in mem_access_unit.

## Test plan
- Memory word 0x40 = 0x8899AABB; LB addr 0x101 -> load_data 0xFFFFFFAA at T+2; LBU -> 0x000000AA; LH addr 0x102 -> 0xFFFF8899; LW addr 0x100 -> 0x8899AABB.
- SB addr 0x102 data 0x12345677 over 0x8899AABB -> mem_we at T+2, word becomes 0x8877AABB, resp_valid at T+3.
- SH addr 0x100 data 0xCAFEBEEF -> word 0x8899BEEF; SW addr 0x104 data 0xDEADBEEF -> mem_we at T, resp_valid T+1.
- LW addr 0x102 and SH addr 0x103 -> resp_err=1 at T+1, mem_we never asserted, load_data=0.
- rst asserted at T+1 of an SB -> no mem_we at T+2, no resp_valid, busy=0 next cycle, memory word unchanged.
- Back-to-back: new LW presented in resp_valid cycle of prior SB -> accepted; reads merged value written by the SB.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, FSM states
// and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LD_WAIT  = 3'd1,
        ST_RMW_WAIT = 3'd2,
        ST_RMW_WR   = 3'd3,
        ST_ERR      = 3'd4
    } lsu_state_t;

    // High when the request is misaligned for its size or uses an encoding
    // that has no meaning for its direction (BU/HU stores, reserved funct3).
    function automatic logic lsu_req_bad(input logic store, input logic [2:0] funct3,
                                         input logic [1:0] lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = lo[0];
            F3_W:    bad = (lo != 2'b00);
            F3_BU:   bad = store;
            F3_HU:   bad = store | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts and extends a load lane from a memory
// word, and merges sub-word store data into a word for read-modify-write.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        unused_store_s;

    assign unused_store_s = ^store_data[31:16];

    // Lane selection: byte k lives at bits [8k+7:8k], upper halfword when lane[1]
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Sign or zero extension of the selected lane
    always_comb begin
        load_ext = 32'h0000_0000;
        case (funct3)
            F3_B:    load_ext = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_ext = {{16{half_s[15]}}, half_s};
            F3_W:    load_ext = word;
            F3_BU:   load_ext = {24'h00_0000, byte_s};
            F3_HU:   load_ext = {16'h0000, half_s};
            default: load_ext = 32'h0000_0000;
        endcase
    end

    // Store-lane merge over the word just read back from memory
    always_comb begin
        merged = word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    2'd3:    merged[31:24] = store_data[7:0];
                    default: merged = word;
                endcase
            end
            F3_H: begin
                if (lane[1]) begin
                    merged[31:16] = store_data[15:0];
                end else begin
                    merged[15:0] = store_data[15:0];
                end
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a word-wide synchronous-read data memory.
// Sub-word stores are done as read-modify-write; bad requests never touch memory.
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_store,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     busy,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [31:0]              load_data,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    lsu_state_t               state_r;
    lsu_state_t               state_s;
    logic [ADDRESS_WIDTH-1:0] idx_r;
    logic [1:0]               lane_r;
    logic [2:0]               funct3_r;
    logic [31:0]              wdata_r;
    logic [31:0]              merged_r;
    logic [31:0]              merged_s;
    logic [31:0]              load_ext_s;
    logic                     req_bad_s;
    logic                     unused_addr_s;

    assign unused_addr_s = ^req_addr[31:ADDRESS_WIDTH+2];
    assign req_bad_s     = lsu_req_bad(req_store, req_funct3, req_addr[1:0]);

    lsu_lane u_lane (
        .lane       (lane_r),
        .funct3     (funct3_r),
        .word       (mem_rdata),
        .store_data (wdata_r),
        .load_ext   (load_ext_s),
        .merged     (merged_s)
    );

    // Next state and memory-side drive; the accept cycle drives memory directly
    always_comb begin
        state_s   = state_r;
        mem_we    = 1'b0;
        mem_addr  = {ADDRESS_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        if (rst) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_bad_s) begin
                            state_s = ST_ERR;
                        end else if (!req_store) begin
                            mem_addr = req_addr[ADDRESS_WIDTH+1:2];
                            state_s  = ST_LD_WAIT;
                        end else if (req_funct3 == F3_W) begin
                            // Full-word store goes straight out; completion is flagged from IDLE
                            mem_we    = 1'b1;
                            mem_addr  = req_addr[ADDRESS_WIDTH+1:2];
                            mem_wdata = req_wdata;
                        end else begin
                            mem_addr = req_addr[ADDRESS_WIDTH+1:2];
                            state_s  = ST_RMW_WAIT;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LD_WAIT: begin
                    mem_addr = idx_r;
                    state_s  = ST_IDLE;
                end
                ST_RMW_WAIT: begin
                    mem_addr = idx_r;
                    state_s  = ST_RMW_WR;
                end
                ST_RMW_WR: begin
                    mem_we    = 1'b1;
                    mem_addr  = idx_r;
                    mem_wdata = merged_r;
                    state_s   = ST_IDLE;
                end
                ST_ERR:  state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, request capture and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            load_data  <= 32'h0000_0000;
            idx_r      <= {ADDRESS_WIDTH{1'b0}};
            lane_r     <= 2'b00;
            funct3_r   <= 3'b000;
            wdata_r    <= 32'h0000_0000;
            merged_r   <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            busy       <= (state_s != ST_IDLE);
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_r    <= req_addr[ADDRESS_WIDTH+1:2];
                        lane_r   <= req_addr[1:0];
                        funct3_r <= req_funct3;
                        wdata_r  <= req_wdata;
                        if (req_bad_s) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            load_data  <= 32'h0000_0000;
                        end else if (req_store && (req_funct3 == F3_W)) begin
                            resp_valid <= 1'b1;
                            load_data  <= 32'h0000_0000;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    load_data  <= load_ext_s;
                    resp_valid <= 1'b1;
                end
                ST_RMW_WAIT: merged_r <= merged_s;
                ST_RMW_WR: begin
                    resp_valid <= 1'b1;
                    load_data  <= 32'h0000_0000;
                end
                default: merged_r <= merged_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized traffic
// against a byte-level reference model of memory.
module tb_mem_access_unit;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_store = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [31:0]   req_addr = 32'h0;
    logic [31:0]   req_wdata = 32'h0;
    logic          busy, resp_valid, resp_err, mem_we;
    logic [31:0]   load_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = 32'h0;

    typedef struct { bit is_load; bit err; logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    logic [31:0] tb_mem [int];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_zero = 1'b0, chk_abort = 1'b0, chk_word = 1'b0, chk_final = 1'b0, to_flag = 1'b0;
    int          word_idx = 0;

    mem_access_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err), .load_data(load_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int idx);
        logic [31:0] v;
        if (idx == 32'h40) return 32'h8899AABB;
        v = 32'(idx) * 32'h9E3779B1;
        return v ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] tb_rd(input int idx);
        if (tb_mem.exists(idx)) return tb_mem[idx];
        return init_word(idx);
    endfunction

    function automatic logic [31:0] ref_rd(input int idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return init_word(idx);
    endfunction

    // Synchronous-read word memory seen by the DUT
    always @(posedge clk) begin
        logic [31:0] rd;
        rd = tb_rd(int'(mem_addr));
        mem_rdata <= rd;
        if (mem_we === 1'b1) tb_mem[int'(mem_addr)] = mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every response and every memory write against the scoreboard
    always @(negedge clk) begin
        resp_t r;
        wr_t   w;
        if (chk_zero) begin
            chk("reset_busy", 32'(busy), 32'h0);
            chk("reset_resp_valid", 32'(resp_valid), 32'h0);
            chk("reset_resp_err", 32'(resp_err), 32'h0);
            chk("reset_load_data", load_data, 32'h0);
            chk("reset_mem_we", 32'(mem_we), 32'h0);
            chk("reset_mem_addr", 32'(mem_addr), 32'h0);
            chk("reset_mem_wdata", mem_wdata, 32'h0);
        end
        if (resp_valid !== 1'b0) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'h0);
            end else begin
                r = rq.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                chk("resp_err", 32'(resp_err), 32'(r.err));
                if (r.is_load || r.err) chk("load_data", load_data, r.data);
            end
        end
        if (mem_we !== 1'b0) begin
            if (wq.size() == 0) begin
                chk("unexpected_mem_we", 32'(mem_we), 32'h0);
            end else begin
                w = wq.pop_front();
                chk("write_cycle", 32'(cyc), 32'(w.cyc));
                chk("write_addr", 32'(mem_addr), 32'(w.addr));
                chk("write_data", mem_wdata, w.data);
            end
        end
        if (chk_abort) begin
            chk("abort_mem_we", 32'(mem_we), 32'h0);
            chk("abort_resp_valid", 32'(resp_valid), 32'h0);
            chk("abort_busy", 32'(busy), 32'h0);
        end
        if (chk_word) chk("abort_word_unchanged", tb_rd(word_idx), ref_rd(word_idx));
        if (chk_final) begin
            chk("resp_queue_empty", 32'(rq.size()), 32'h0);
            chk("write_queue_empty", 32'(wq.size()), 32'h0);
            for (int i = 32'h3C; i <= 32'h47; i++) chk("final_mem", tb_rd(i), ref_rd(i));
        end
        if (to_flag) chk("handshake_timeout", 32'h1, 32'h0);
    end

    // Issue one request: compute expectations from the reference model, drive, wait for completion
    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        resp_t       r;
        wr_t         w;
        int          k, idx, sh;
        bit          bad, got, done;
        logic [31:0] word, v, mask;
        k    = cyc;
        idx  = int'(a[17:2]);
        sh   = 8 * int'(a[1:0]);
        bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
               (st && (f3 == 3'd4 || f3 == 3'd5)) ||
               ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) ||
               ((f3 == 3'd2) && (a % 4 != 0));
        word = ref_rd(idx);
        v    = word >> sh;
        r.is_load = !st;
        r.err     = bad;
        r.data    = 32'h0;
        if (bad) begin
            r.cyc = k + 1;
        end else if (!st) begin
            r.cyc = k + 2;
            case (f3)
                3'd0:    r.data = {{24{v[7]}}, v[7:0]};
                3'd1:    r.data = {{16{v[15]}}, v[15:0]};
                3'd4:    r.data = {24'h0, v[7:0]};
                3'd5:    r.data = {16'h0, v[15:0]};
                default: r.data = word;
            endcase
        end else if (f3 == 3'd2) begin
            r.cyc = k + 1;
            w = '{addr: AW'(idx), data: wd, cyc: k};
            wq.push_back(w);
            ref_mem[idx] = wd;
        end else begin
            r.cyc = k + 3;
            mask  = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
            w = '{addr: AW'(idx), data: (word & ~(mask << sh)) | ((wd & mask) << sh), cyc: k + 2};
            wq.push_back(w);
            ref_mem[idx] = w.data;
        end
        rq.push_back(r);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            if (resp_valid === 1'b1) got = 1'b1;
            if (got && busy === 1'b0) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) begin
            to_flag = 1'b1; @(posedge clk); #1; to_flag = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        bit          st;
        logic [2:0]  ld_f3 [5];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        repeat (3) @(posedge clk);
        #1 chk_zero = 1'b1;
        @(posedge clk); #1;
        chk_zero = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases around word 0x40 = 0x8899AABB
        issue(1'b0, 3'd0, 32'h101, 32'h0);
        issue(1'b0, 3'd4, 32'h101, 32'h0);
        issue(1'b0, 3'd1, 32'h102, 32'h0);
        issue(1'b0, 3'd2, 32'h100, 32'h0);
        issue(1'b1, 3'd0, 32'h102, 32'h12345677);
        issue(1'b0, 3'd2, 32'h100, 32'h0);
        issue(1'b1, 3'd1, 32'h100, 32'hCAFEBEEF);
        issue(1'b1, 3'd2, 32'h104, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'h102, 32'h0);
        issue(1'b1, 3'd1, 32'h103, 32'h0BAD0BAD);
        issue(1'b1, 3'd4, 32'h100, 32'h0);
        issue(1'b0, 3'd7, 32'h100, 32'h0);

        // Reset one cycle after accepting an SB: the access must vanish
        word_idx = 32'h42;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h109; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_abort = 1'b1;
        @(posedge clk); #1;
        chk_abort = 1'b0;
        chk_word = 1'b1;
        @(posedge clk); #1;
        chk_word = 1'b0;

        // Randomized traffic, mostly legal, confined to a few words so data is reused
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h0F0 + 32'($urandom_range(0, 47));
            if ($urandom_range(0, 3) != 0) begin
                f3 = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
                if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
                if (f3 == 3'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFC_0000);
            issue(st, f3, a, $urandom);
        end

        repeat (2) @(posedge clk);
        #1 chk_final = 1'b1;
        @(posedge clk); #1;
        chk_final = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
